// File: rtl/register_file_if.sv
// register_file_if: decode/writeback-side bus of the integer register file.
// master drives indices, enables and write data; slave returns both read ports.
interface register_file_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  we;
    logic                  re;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;

    modport master (
        output we, re, rs1, rs2, rd, write_data,
        input  read_data_1, read_data_2
    );

    modport slave (
        input  we, re, rs1, rs2, rd, write_data,
        output read_data_1, read_data_2
    );
endinterface

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH integer registers, x0 reads zero, one write and two registered reads.
// Define REGISTERS_BYPASS_EN to forward same-edge write data to a matching read port.
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
    logic                  write_valid_c;

    assign write_valid_c = bus.we && (bus.rd != '0);

    // Storage next state; entry 0 is pinned to zero so it never holds data.
    always_comb begin
        regs_d = regs_q;
        if (write_valid_c) begin
            regs_d[bus.rd] = bus.write_data;
        end
        regs_d[0] = '0;
    end

    // Read ports capture only when re is high, otherwise hold.
    always_comb begin
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        if (bus.re) begin
            rdata1_d = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
            rdata2_d = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
`ifdef REGISTERS_BYPASS_EN
            if (write_valid_c && (bus.rs1 == bus.rd)) begin
                rdata1_d = bus.write_data;
            end
            if (write_valid_c && (bus.rs2 == bus.rd)) begin
                rdata2_d = bus.write_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q   <= '{default: '0};
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            regs_q   <= regs_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign bus.read_data_1 = rdata1_q;
    assign bus.read_data_2 = rdata2_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test-plan steps plus random traffic checked against an array model.
// Honours REGISTERS_BYPASS_EN the same way as the design build.
module tb_register_file;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] model [16];
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;

    register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        exp1 = '0;
        exp2 = '0;
    endtask

    // One clock: drive at negedge, update the model at posedge, compare just after.
    task automatic cycle(input logic w, input logic r, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        @(negedge clk);
        bus.we = w; bus.re = r; bus.rs1 = a1; bus.rs2 = a2; bus.rd = ad; bus.write_data = wd;
        @(posedge clk);
        if (r) begin
            exp1 = model[a1];
            exp2 = model[a2];
`ifdef REGISTERS_BYPASS_EN
            if (w && ad != 0 && a1 == ad) exp1 = wd;
            if (w && ad != 0 && a2 == ad) exp2 = wd;
`endif
        end
        if (w && ad != 0) model[ad] = wd;
        #1;
        check("model_rd1", bus.read_data_1, exp1);
        check("model_rd2", bus.read_data_2, exp2);
    endtask

    initial begin
        reset = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0; bus.write_data = '0;
        clear_model();
        #1;
        check("reset_rd1", bus.read_data_1, 32'h0);
        check("reset_rd2", bus.read_data_2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Load x1..x15 with their own index, then read back in pairs.
        for (int i = 1; i < 16; i++) cycle(1'b1, 1'b0, '0, '0, AW'(i), DW'(i));
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, AW'(2 * k), AW'(2 * k + 1), '0, '0);
            check("pair_rd1", bus.read_data_1, DW'(2 * k));
            check("pair_rd2", bus.read_data_2, DW'(2 * k + 1));
        end

        // Writes to x0 are discarded.
        cycle(1'b1, 1'b0, '0, '0, '0, 32'h9999_9999);
        cycle(1'b0, 1'b1, '0, 4'd2, '0, '0);
        check("x0_rd1", bus.read_data_1, 32'h0);
        check("x0_rd2", bus.read_data_2, 32'h2);

        // Outputs hold while re is low, even across index changes and writes.
        cycle(1'b0, 1'b1, 4'd3, 4'd4, '0, '0);
        check("hold_pre_rd1", bus.read_data_1, 32'h3);
        check("hold_pre_rd2", bus.read_data_2, 32'h4);
        cycle(1'b0, 1'b0, 4'd5, 4'd6, '0, '0);
        check("hold_rd1", bus.read_data_1, 32'h3);
        check("hold_rd2", bus.read_data_2, 32'h4);
        cycle(1'b1, 1'b0, 4'd5, 4'd6, 4'd3, 32'hDEAD_BEEF);
        check("hold_wr_rd1", bus.read_data_1, 32'h3);
        cycle(1'b0, 1'b1, 4'd5, 4'd6, '0, '0);
        check("hold_post_rd1", bus.read_data_1, 32'h5);
        check("hold_post_rd2", bus.read_data_2, 32'h6);

        // Same-edge read and write of x5.
        cycle(1'b1, 1'b1, 4'd5, 4'd6, 4'd5, 32'hA5A5_A5A5);
`ifdef REGISTERS_BYPASS_EN
        check("same_edge_rd1", bus.read_data_1, 32'hA5A5_A5A5);
`else
        check("same_edge_rd1", bus.read_data_1, 32'h5);
`endif
        check("same_edge_rd2", bus.read_data_2, 32'h6);
        cycle(1'b0, 1'b1, 4'd5, 4'd5, '0, '0);
        check("after_edge_rd1", bus.read_data_1, 32'hA5A5_A5A5);
        check("after_edge_rd2", bus.read_data_2, 32'hA5A5_A5A5);

        // Reset pulse between edges clears outputs without a clock.
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_rd1", bus.read_data_1, 32'h0);
        check("async_rd2", bus.read_data_2, 32'h0);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, AW'(2 * k), AW'(2 * k + 1), '0, '0);
            check("cleared_rd1", bus.read_data_1, 32'h0);
            check("cleared_rd2", bus.read_data_2, 32'h0);
        end

        // Reset asserted while a write to x7 is pending loses the write.
        cycle(1'b1, 1'b0, '0, '0, 4'd7, 32'h77);
        @(negedge clk);
        bus.we = 1'b1; bus.re = 1'b0; bus.rd = 4'd7; bus.write_data = 32'h1234_5678;
        #1 reset = 1'b1;
        clear_model();
        @(negedge clk);
        bus.we = 1'b0;
        reset = 1'b0;
        cycle(1'b0, 1'b1, 4'd7, '0, '0, '0);
        check("wr_reset_x7", bus.read_data_1, 32'h0);

        // Random traffic against the array model.
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 15)), DW'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
